// File: rtl/ip_codma_crc_engine.sv
// ip_codma_crc_engine: streaming CRC engine. Each accepted word is folded into
// the CRC register MSB first, BPC bits per clock. The final word of a message
// produces a one-cycle done pulse carrying the CRC and a compare result.
module ip_codma_crc_engine #(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               DATA_W  = 32,
  parameter int               BPC     = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic [CRC_W-1:0]  expected_i,
  output logic [CRC_W-1:0]  crc_o,
  output logic              done_o,
  output logic              match_o,
  output logic              busy_o
);

  localparam int STEPS = DATA_W / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  // A word must split into a whole number of per-clock slices.
  if ((DATA_W % BPC) != 0) begin : g_bad_bpc
    $error("ip_codma_crc_engine: DATA_W must be a multiple of BPC");
  end
  if ((CRC_W < 8) || (CRC_W > 32)) begin : g_bad_crc_w
    $error("ip_codma_crc_engine: CRC_W must lie in 8..32");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               last_q, last_d;
  logic [CRC_W-1:0]   crc_out_q, crc_out_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  // BPC serial LFSR steps, consuming the slice from its MSB downwards.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                input logic [BPC-1:0]   bits);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ bits[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // Next-state logic: start/accept in IDLE, one slice per cycle in SHIFT,
  // result publication and register reload in DONE.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    last_d    = last_q;
    crc_out_d = crc_out_q;
    match_d   = match_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          crc_d = INIT;
        end
        if (in_valid_i) begin
          data_d  = in_data_i;
          last_d  = in_last_i;
          cnt_d   = CNT_W'(STEPS - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        crc_d  = crc_step(crc_q, data_q[DATA_W-1 -: BPC]);
        data_d = data_q << BPC;
        if (cnt_q == '0) begin
          if (last_q) begin
            state_d   = DONE;
            done_d    = 1'b1;
            crc_out_d = crc_d ^ XOR_OUT;
            match_d   = ((crc_d ^ XOR_OUT) == expected_i);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        crc_d   = INIT;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset discards any message in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      cnt_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      crc_out_q <= '0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      last_q    <= last_d;
      crc_out_q <= crc_out_d;
      match_q   <= match_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign in_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign crc_o      = crc_out_q;
  assign match_o    = match_q;

endmodule

// File: doc/ip_codma_crc_engine.md
IP_CODMA_CRC_ENGINE -- requirements
Module: ip_codma_crc_engine

Interface
REQ-001 Parameter CRC_W, default 16, CRC register width (8..32).
REQ-002 Parameter POLY, default 16'h1021, generator polynomial without the implicit x^CRC_W term.
REQ-003 Parameter INIT, default all-ones, CRC register start value.
REQ-004 Parameter XOR_OUT, default 0, value XORed into the result.
REQ-005 Parameter DATA_W, default 32, input word width.
REQ-006 Parameter BPC, default 8, bits processed per clock; DATA_W % BPC != 0 SHALL raise an elaboration error.
REQ-007 clk_i  input  1  clock; rising edge active.
REQ-008 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-009 start_i  input  1  pulse; reload CRC register with INIT.
REQ-010 in_valid_i  input  1  data word valid.
REQ-011 in_ready_o  output  1  engine can accept a word.
REQ-012 in_data_i  input  DATA_W  message word; MSB processed first.
REQ-013 in_last_i  input  1  word is the final word of the message.
REQ-014 expected_i  input  CRC_W  reference CRC for hardware check.
REQ-015 crc_o  output  CRC_W  final CRC (register ^ XOR_OUT), held until next done.
REQ-016 done_o  output  1  one-cycle pulse; crc_o/match_o valid.
REQ-017 match_o  output  1  crc_o == expected_i, sampled at done.
REQ-018 busy_o  output  1  high in SHIFT or DONE.

Function
REQ-019 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-020 in_ready_o SHALL be 1 only in IDLE; word accepted when in_valid_i && in_ready_o.
REQ-021 start_i in IDLE SHALL load INIT into the CRC register; start_i outside IDLE SHALL be ignored.
REQ-022 start_i and an accepted word in the same cycle: INIT is applied first, then the word is processed against INIT.
REQ-023 On accept: latch in_data_i and in_last_i, step counter = DATA_W/BPC-1, go to SHIFT.
REQ-024 SHIFT: each cycle apply BPC serial LFSR steps, MSB first: fb = crc[CRC_W-1] ^ bit; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W.
REQ-025 SHIFT with counter 0: go to DONE if the latched last flag is set, else go to IDLE; otherwise decrement the counter.
REQ-026 DONE (one cycle): done_o = 1, crc_o = crc ^ XOR_OUT, match_o = (crc ^ XOR_OUT) == expected_i; CRC register reloads INIT; go to IDLE.
REQ-027 Latency: a last word accepted at edge t SHALL give done_o at cycle t + DATA_W/BPC + 1.
REQ-028 Throughput: one word per DATA_W/BPC + 1 cycles for non-last words; a last word adds one further DONE cycle.
REQ-029 in_data_i changes while not ready SHALL have no effect; the CRC register is held between words of one message.
REQ-030 crc_o and match_o SHALL hold their values until the next DONE.

Reset
REQ-031 Asynchronous reset SHALL force: state IDLE, CRC register INIT, counter 0, crc_o 0, match_o 0, done_o 0, busy_o 0, in_ready_o 1.
REQ-032 Reset asserted mid-SHIFT SHALL discard the partial message; no done_o pulse SHALL follow release.
REQ-033 First word accepted after reset without start_i SHALL use INIT.

Verification
REQ-034 CRC_W=16, POLY=0x1021, INIT=0, DATA_W=8, BPC=1; bytes "123456789" (0x31..0x39), last on 0x39 -> crc_o=0x31C3, done_o one cycle, 9 cycles after the last accept.
REQ-035 Same configuration with INIT=0xFFFF, expected_i=0x29B1 -> crc_o=0x29B1, match_o=1; expected_i=0x29B0 -> match_o=0.
REQ-036 CRC_W=32, POLY=0x04C11DB7, INIT=0xFFFFFFFF, DATA_W=8, BPC=8; "123456789" -> crc_o=0x0376E6E7, each byte taking 1 SHIFT cycle.
REQ-037 INIT=0, DATA_W=8, single byte 0x01 with last -> crc_o=0x1021; in_valid_i held high through SHIFT/DONE -> no second accept until in_ready_o=1.
REQ-038 Reset pulsed during SHIFT of the third byte of "123456789" -> outputs return to reset values with no done_o; full resend -> correct 0x31C3 (INIT=0 configuration).
